// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit for the 5-stage SimpleRISC pipeline.
// Each load that leaves D takes a countdown entry for LOAD_LAT cycles.
// While any source register of the decode instruction matches a live
// entry, add_stall holds F/D and sends a bubble into E. A saturating
// counter records the number of stall cycles.
`timescale 1ns/1ps
module load_use_scoreboard #(
    parameter int REG_AW    = 4,
    parameter int LOAD_LAT  = 1,
    parameter int STORE_FWD = 1,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            instruction_D,
    input  logic                   valid_D,
    input  logic                   flush,
    input  logic                   cnt_clr,
    output logic                   add_stall,
    output logic [2**REG_AW-1:0]   pend_mask,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int NREG = 2**REG_AW;
    localparam int LW   = $clog2(LOAD_LAT + 1);

    localparam logic [4:0] OP_ALU_LAST = 5'b01100;
    localparam logic [4:0] OP_NOT      = 5'b01000;
    localparam logic [4:0] OP_MOV      = 5'b01001;
    localparam logic [4:0] OP_NOP      = 5'b01101;
    localparam logic [4:0] OP_LD       = 5'b01110;
    localparam logic [4:0] OP_ST       = 5'b01111;
    localparam logic [4:0] OP_RET      = 5'b10100;

    localparam logic [LW-1:0]     CNT_ONE  = LW'(1);
    localparam logic [LW-1:0]     CNT_INIT = LW'(LOAD_LAT);
    localparam logic [CNT_W-1:0]  SCNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  SCNT_MAX = {CNT_W{1'b1}};
    localparam logic [REG_AW-1:0] RA_REG   = {REG_AW{1'b1}};

    // One-hot decode of a register number into a register mask.
    function automatic logic [NREG-1:0] onehot_f(input logic [REG_AW-1:0] r);
        onehot_f = {{(NREG-1){1'b0}}, 1'b1} << r;
    endfunction

    // Instruction fields
    logic [4:0]        opcode_s;
    logic              imm_s;
    logic [REG_AW-1:0] rd_s;
    logic [REG_AW-1:0] rs1_s;
    logic [REG_AW-1:0] rs2_s;
    logic              unused_bits_s;

    assign opcode_s      = instruction_D[31:27];
    assign imm_s         = instruction_D[26];
    assign rd_s          = instruction_D[25 -: REG_AW];
    assign rs1_s         = instruction_D[25 - REG_AW -: REG_AW];
    assign rs2_s         = instruction_D[25 - 2*REG_AW -: REG_AW];
    assign unused_bits_s = ^instruction_D[25 - 3*REG_AW:0];

    // Source usage flags
    logic            use_rs1_s;
    logic            use_rs2_s;
    logic            use_rd_s;
    logic            use_ra_s;
    logic            is_ld_s;
    logic [NREG-1:0] src_mask_s;
    logic            add_stall_s;
    logic            alloc_s;

    // Scoreboard entries
    logic [LOAD_LAT-1:0]             busy_q;
    logic [LOAD_LAT-1:0]             busy_d;
    logic [LOAD_LAT-1:0][REG_AW-1:0] reg_q;
    logic [LOAD_LAT-1:0][REG_AW-1:0] reg_d;
    logic [LOAD_LAT-1:0][LW-1:0]     cnt_q;
    logic [LOAD_LAT-1:0][LW-1:0]     cnt_d;
    logic [LOAD_LAT-1:0]             grant_s;
    logic                            taken_s;
    logic [NREG-1:0]                 pend_mask_q;
    logic [NREG-1:0]                 pend_mask_d;
    logic [CNT_W-1:0]                stall_cnt_q;
    logic [CNT_W-1:0]                stall_cnt_d;

    // Decode which register fields the decode-stage instruction reads.
    always_comb begin
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        use_rd_s  = 1'b0;
        use_ra_s  = 1'b0;
        is_ld_s   = 1'b0;
        case (opcode_s)
            OP_NOT, OP_MOV: begin
                use_rs2_s = ~imm_s;
            end
            OP_NOP: begin
                use_rs1_s = 1'b0;
            end
            OP_LD: begin
                use_rs1_s = 1'b1;
                is_ld_s   = 1'b1;
            end
            OP_ST: begin
                use_rs1_s = 1'b1;
                use_rd_s  = (STORE_FWD == 0) ? 1'b1 : 1'b0;
            end
            OP_RET: begin
                use_ra_s = 1'b1;
            end
            default: begin
                // Remaining ALU ops (cmp included) read rs1 and, unless immediate, rs2;
                // branches and undefined opcodes read nothing.
                if (opcode_s <= OP_ALU_LAST) begin
                    use_rs1_s = 1'b1;
                    use_rs2_s = ~imm_s;
                end else begin
                    use_rs1_s = 1'b0;
                end
            end
        endcase
    end

    // Build the read mask and compare it against the registered pending mask.
    always_comb begin
        src_mask_s = {NREG{1'b0}};
        if (use_rs1_s) src_mask_s = src_mask_s | onehot_f(rs1_s);
        else           src_mask_s = src_mask_s;
        if (use_rs2_s) src_mask_s = src_mask_s | onehot_f(rs2_s);
        else           src_mask_s = src_mask_s;
        if (use_rd_s)  src_mask_s = src_mask_s | onehot_f(rd_s);
        else           src_mask_s = src_mask_s;
        if (use_ra_s)  src_mask_s = src_mask_s | onehot_f(RA_REG);
        else           src_mask_s = src_mask_s;
        add_stall_s = valid_D & ~flush & (|(src_mask_s & pend_mask_q));
        alloc_s     = valid_D & ~flush & ~add_stall_s & is_ld_s;
    end

    // Pick the first entry that is free or retiring this edge for a new load.
    always_comb begin
        grant_s = {LOAD_LAT{1'b0}};
        taken_s = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (alloc_s && !taken_s && (!busy_q[i] || (cnt_q[i] == CNT_ONE))) begin
                grant_s[i] = 1'b1;
                taken_s    = 1'b1;
            end else begin
                taken_s = taken_s;
            end
        end
    end

    // Entry countdown, allocation and the next pending mask.
    always_comb begin
        busy_d      = busy_q;
        reg_d       = reg_q;
        cnt_d       = cnt_q;
        pend_mask_d = {NREG{1'b0}};
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (grant_s[i]) begin
                busy_d[i] = 1'b1;
                reg_d[i]  = rd_s;
                cnt_d[i]  = CNT_INIT;
            end else if (busy_q[i]) begin
                busy_d[i] = (cnt_q[i] != CNT_ONE);
                cnt_d[i]  = cnt_q[i] - CNT_ONE;
            end else begin
                busy_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (busy_d[i]) pend_mask_d = pend_mask_d | onehot_f(reg_d[i]);
            else           pend_mask_d = pend_mask_d;
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        if (cnt_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (add_stall_s && (stall_cnt_q != SCNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + SCNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= {LOAD_LAT{1'b0}};
            reg_q       <= '0;
            cnt_q       <= '0;
            pend_mask_q <= {NREG{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            busy_q      <= busy_d;
            reg_q       <= reg_d;
            cnt_q       <= cnt_d;
            pend_mask_q <= pend_mask_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign add_stall = add_stall_s;
    assign pend_mask = pend_mask_q;
    assign stall_cnt = stall_cnt_q;

endmodule
